layer_serializer: RTL

- Parallel-to-serial converter between fully-connected layers.
- Captures the NN parallel neuron outputs of one layer in a single cycle when all neuron valids assert.
- Replays the captured words one per cycle as a data/valid stream shaped for the broadcast serial input of the next layer.
- Sits between layer N outputs (x_out/o_valid style buses) and layer N+1 inputs (x_in/x_valid style).

---
 rtl/layer_serializer.sv | 98 +++++++++
 1 files changed

// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge between fully-connected layers: grabs all NN neuron
// outputs in one cycle, then streams them one word per cycle to the next layer.
module layer_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NN-1:0]             i_valid,
  input  logic [NN*dataWidth-1:0]   i_data,
  output logic                      o_valid,
  output logic [dataWidth-1:0]      o_data,
  output logic                      o_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_SHIFT  = 1'b1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);

  logic [0:0]                     state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d, idx_inc;
  logic [NN-1:0][dataWidth-1:0]   buf_q, buf_d;
  logic                           o_valid_q, o_valid_d;
  logic [dataWidth-1:0]           o_data_q, o_data_d;
  logic                           o_last_q, o_last_d;
  logic                           overrun_q, overrun_d;
  logic                           trigger, load;

  assign trigger = &i_valid;
  assign idx_inc = idx_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    o_valid_d = 1'b0;
    o_data_d  = '0;
    o_last_d  = 1'b0;
    overrun_d = overrun_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: load = trigger;
      default: begin
        if (idx_q != IDX_LAST) begin
          // Mid-frame triggers are dropped; the current frame runs to completion.
          idx_d     = idx_inc;
          o_valid_d = 1'b1;
          o_data_d  = buf_q[idx_inc];
          o_last_d  = (idx_inc == IDX_LAST);
          if (trigger) overrun_d = 1'b1;
        end else if (trigger) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    // Capture and present word 0 on the same edge so there is no bubble.
    if (load) begin
      state_d   = S_SHIFT;
      idx_d     = '0;
      buf_d     = i_data;
      o_valid_d = 1'b1;
      o_data_d  = i_data[dataWidth-1:0];
      o_last_d  = (IDX_LAST == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge CLK) buf_q <= buf_d;

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_last  = o_last_q;
  assign busy    = (state_q == S_SHIFT);
  assign overrun = overrun_q;

endmodule
